// File: rtl/fp_mul_single_iter.sv
// -----------------------------------------------------------------------------
// fp_mul_single_iter
//   Sequential front end of the single-precision FP multiplier. Takes two
//   IEEE-754 words over a valid/ready handshake and forms the 2*MW-bit product
//   of the two mantissas (hidden 1 set) with an iterative shift-add datapath,
//   together with the biased exponent sum and the result sign. The outputs feed
//   mantissa_mul_single, which normalises and rounds.
//
//   FSM: IDLE -> BUSY -> DONE -> IDLE. An exact-zero operand (whole word == 0)
//   skips BUSY and goes straight to DONE with mo=0, zero=1.
//
// Configuration macro:
//   MUL_RADIX4_EN  - retire two multiplier bits per BUSY cycle (MW/2 cycles)
//                    using a {0,1x,2x,3x} addend; 3x is formed at accept.
//                    Undefined: radix-2, MW cycles. mo is identical either way.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair a/b valid
//   in_ready   out  1      block can accept operands (IDLE)
//   a, b       in   32     IEEE-754 single operands
//   out_valid  out  1      mo/eo/so/zero valid (DONE)
//   out_ready  in   1      downstream consumes the result
//   mo         out  2*MW   {1,ma}*{1,mb}, or 0 for an exact-zero operand
//   eo         out  EW     e1+e2-BIAS modulo 2^EW (wraps, no flag)
//   so         out  1      a[31]^b[31]
//   zero       out  1      a==0 or b==0
// -----------------------------------------------------------------------------
module fp_mul_single_iter #(
  parameter int MW   = 24,
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*MW-1:0] mo,
  output logic [EW-1:0]   eo,
  output logic            so,
  output logic            zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(MW);

`ifdef MUL_RADIX4_EN
  localparam int STEPS = MW / 2;
  localparam int SW    = MW + 2;   // P_hi + 3*{1,ma} needs two extra bits
`else
  localparam int STEPS = MW;
  localparam int SW    = MW + 1;
`endif

  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // ---------------------------------------------------------------------------
  // Operand decode (only meaningful on the accept edge)
  // ---------------------------------------------------------------------------
  logic [MW-1:0]   w_ma_full;
  logic [MW-1:0]   w_mb_full;
  logic [EW-1:0]   w_ea;
  logic [EW-1:0]   w_eb;
  logic [EW+1:0]   w_esum;
  logic            w_any_zero;

  assign w_ma_full  = {1'b1, a[MW-2:0]};
  assign w_mb_full  = {1'b1, b[MW-2:0]};
  assign w_ea       = a[MW-1 +: EW];
  assign w_eb       = b[MW-1 +: EW];
  // Two guard bits keep the intermediate sum exact; only the low EW bits are
  // kept, so overflow and underflow simply wrap.
  assign w_esum     = {2'b00, w_ea} + {2'b00, w_eb} - (EW+2)'(BIAS);
  assign w_any_zero = (a == 32'd0) || (b == 32'd0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2*MW-1:0] r_p;      // {partial product, remaining multiplier bits}
  logic [MW-1:0]   r_ma;     // {1,ma} multiplicand
  logic [EW-1:0]   r_eo;
  logic            r_so;
  logic            r_zero;

  // ---------------------------------------------------------------------------
  // One shift-add step
  // ---------------------------------------------------------------------------
  logic [SW-1:0]   w_add;
  logic [SW-1:0]   w_sum;
  logic [2*MW-1:0] w_p_next;

`ifdef MUL_RADIX4_EN
  logic [SW-1:0]   r_ma3;    // 3*{1,ma}, formed once at accept

  // NOTE: every always_comb output gets a default before the case so that
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_add = '0;
    unique case (r_p[1:0])
      2'b01:   w_add = {2'b00, r_ma};
      2'b10:   w_add = {1'b0, r_ma, 1'b0};
      2'b11:   w_add = r_ma3;
      default: w_add = '0;
    endcase
  end

  assign w_sum    = {2'b00, r_p[2*MW-1:MW]} + w_add;
  assign w_p_next = {w_sum, r_p[MW-1:2]};
`else
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    w_add = '0;
    if (r_p[0]) w_add = {1'b0, r_ma};
  end

  assign w_sum    = {1'b0, r_p[2*MW-1:MW]} + w_add;
  assign w_p_next = {w_sum, r_p[MW-1:1]};
`endif

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_ma    <= '0;
      r_eo    <= '0;
      r_so    <= 1'b0;
      r_zero  <= 1'b0;
`ifdef MUL_RADIX4_EN
      r_ma3   <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_so  <= a[31] ^ b[31];
            r_eo  <= w_esum[EW-1:0];
            r_ma  <= w_ma_full;
            r_cnt <= '0;
`ifdef MUL_RADIX4_EN
            r_ma3 <= {2'b00, w_ma_full} + {1'b0, w_ma_full, 1'b0};
`endif
            if (w_any_zero) begin
              r_p     <= '0;
              r_zero  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_p     <= {{MW{1'b0}}, w_mb_full};
              r_zero  <= 1'b0;
              r_state <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_DONE;
        end

        S_DONE: begin
          // in_ready only rises after this edge, so nothing is accepted in
          // the same cycle the result is consumed.
          if (out_ready) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign mo        = r_p;
  assign eo        = r_eo;
  assign so        = r_so;
  assign zero      = r_zero;

endmodule

// File: tb/tb_fp_mul_single_iter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_single_iter
//   Self-checking bench for fp_mul_single_iter: reset state, a table of
//   hand-computed vectors, backpressure hold, in_valid ignored while busy,
//   reset abort mid-operation, and 100 back-to-back random pairs against a
//   {1,ma}*{1,mb} model. Honours MUL_RADIX4_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_fp_mul_single_iter;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif
  localparam int TMO = 200;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] mo;
  logic [7:0]  eo;
  logic        so;
  logic        zero;

  int checks = 0;
  int errors = 0;

  fp_mul_single_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mo        (mo),
    .eo        (eo),
    .so        (so),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] mo;
    logic [7:0]  eo;
    logic        so;
    logic        zero;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks are entered and left #1 after a rising edge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;  // operands need only be stable on the accept edge
    b        = 32'h0BAD_F00D;
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [47:0] emo, input logic [7:0] eeo,
                              input logic eso, input logic ezero);
    check({tag, "_mo"},   {16'd0, mo}, {16'd0, emo});
    check({tag, "_eo"},   {56'd0, eo}, {56'd0, eeo});
    check({tag, "_so"},   {63'd0, so}, {63'd0, eso});
    check({tag, "_zero"}, {63'd0, zero}, {63'd0, ezero});
  endtask

  initial begin
    int          lat;
    logic [47:0] held_mo;
    logic [7:0]  held_eo;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [47:0] emo;
    logic [9:0]  esum;

    // a, b, mo, eo, so, zero (hand-computed)
    vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 48'h6000_0000_0000, 8'h80, 1'b0, 1'b0}; // 1.5*2
    vecs[1] = '{32'hC000_0000, 32'h4040_0000, 48'h6000_0000_0000, 8'h81, 1'b1, 1'b0}; // -2*3
    vecs[2] = '{32'h0000_0000, 32'h3F80_0000, 48'h0000_0000_0000, 8'h00, 1'b0, 1'b1}; // 0*1
    vecs[3] = '{32'h3F80_0000, 32'h3F80_0000, 48'h4000_0000_0000, 8'h7F, 1'b0, 1'b0}; // 1*1
    vecs[4] = '{32'hBF80_0000, 32'h0000_0000, 48'h0000_0000_0000, 8'h00, 1'b1, 1'b1}; // -1*0
    vecs[5] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 48'hFFFF_FE00_0001, 8'h7F, 1'b0, 1'b0}; // max mantissa
    vecs[6] = '{32'h7F00_0000, 32'h7F00_0000, 48'h4000_0000_0000, 8'h7D, 1'b0, 1'b0}; // exp overflow wraps
    vecs[7] = '{32'h0080_0000, 32'h0080_0000, 48'h4000_0000_0000, 8'h83, 1'b0, 1'b0}; // exp underflow wraps
    vecs[8] = '{32'h8000_0000, 32'h3F80_0000, 48'h4000_0000_0000, 8'h00, 1'b1, 1'b0}; // -0 is not whole-word zero
    vecs[9] = '{32'h4049_0FDB, 32'h3F80_0000, 48'h6487_ED80_0000, 8'h80, 1'b0, 1'b0}; // pi*1

    rst_n     = 1'b0;
    in_valid  = 1'b1;          // must be ignored while in reset
    a         = 32'h3FC0_0000;
    b         = 32'h4000_0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_result("rst", 48'd0, 8'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven vectors, out_ready held high -------------------------
    for (int i = 0; i < 10; i++) begin
      wait_ready();
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      // zero operand bypasses BUSY: result visible right after the accept edge
      check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].zero ? 64'd0 : 64'(LAT));
      check_result($sformatf("vec%0d", i), vecs[i].mo, vecs[i].eo, vecs[i].so, vecs[i].zero);
    end
    @(posedge clk); #1;        // drain the last result

    // ---- backpressure: out_ready low for 5 cycles in DONE ------------------
    out_ready = 1'b0;
    wait_ready();
    start_op(32'h3F80_0000, 32'h3F80_0000);
    wait_done(lat);
    check_result("bp", 48'h4000_0000_0000, 8'h7F, 1'b0, 1'b0);
    held_mo = mo;
    held_eo = eo;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'd0, in_ready}, 64'd0);
      check("bp_mo_hold",   {16'd0, mo}, {16'd0, held_mo});
      check("bp_eo_hold",   {56'd0, eo}, {56'd0, held_eo});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_in_ready",  {63'd0, in_ready}, 64'd1);

    // ---- in_valid during BUSY is ignored ----------------------------------
    start_op(32'hC000_0000, 32'h4040_0000);
    in_valid = 1'b1;
    a        = 32'h0000_0000;
    b        = 32'h0000_0000;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat + 5), 64'(LAT));
    check_result("ign", 48'h6000_0000_0000, 8'h81, 1'b1, 1'b0);
    @(posedge clk); #1;

    // ---- reset abort at cycle 10 of BUSY -----------------------------------
    wait_ready();
    start_op(32'h3FC0_0000, 32'h4000_0000);
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready",  {63'd0, in_ready}, 64'd1);
    check_result("abort", 48'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_post_in_ready", {63'd0, in_ready}, 64'd1);
    start_op(32'h3FC0_0000, 32'h4000_0000);
    wait_done(lat);
    check("abort_redo_lat", 64'(lat), 64'(LAT));
    check_result("abort_redo", 48'h6000_0000_0000, 8'h80, 1'b0, 1'b0);

    // ---- 100 back-to-back random pairs vs model ----------------------------
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 3) ra = 32'd0;
      if (i % 10 == 7) rb = 32'd0;
      if (ra == 32'd0 || rb == 32'd0) emo = 48'd0;
      else emo = 48'({1'b1, ra[22:0]}) * 48'({1'b1, rb[22:0]});
      esum = {2'b00, ra[30:23]} + {2'b00, rb[30:23]} - 10'd127;
      wait_ready();
      start_op(ra, rb);
      wait_done(lat);
      check($sformatf("rnd%0d_lat", i), 64'(lat), (ra == 0 || rb == 0) ? 64'd0 : 64'(LAT));
      check_result($sformatf("rnd%0d", i), emo, esum[7:0], ra[31] ^ rb[31],
                   (ra == 0 || rb == 0));
    end
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
